// File: rtl/perceptron_trainer.sv
// Perceptron training step: latch a sample, form the error and scaled rate,
// then update one weight per cycle with saturating fixed-point arithmetic.
module perceptron_trainer #(
    parameter int SIGN     = 1,
    parameter int Q_M      = 15,
    parameter int Q_N      = 16,
    parameter int N_INPUTS = 4,
    localparam int W       = SIGN + Q_M + Q_N,
    localparam int IW      = $clog2(N_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [IW-1:0]         load_index,
    input  logic [W-1:0]          load_value,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [W-1:0]          target,
    input  logic [W-1:0]          activation,
    input  logic [W-1:0]          learning_rate,
    input  logic [N_INPUTS*W-1:0] inputs,
    output logic [N_INPUTS*W-1:0] weights,
    output logic [W-1:0]          error_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] a);
        return {{W{a[W-1]}}, a};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [2*W-1:0] v);
        if (v > MAXV)
            return {1'b0, {(W-1){1'b1}}};
        else if (v < MINV)
            return {1'b1, {(W-1){1'b0}}};
        else
            return v[W-1:0];
    endfunction

    state_t                      r_state;
    state_t                      w_next;
    logic [N_INPUTS-1:0][W-1:0]  r_w;
    logic [N_INPUTS-1:0][W-1:0]  r_x;
    logic [W-1:0]                r_tgt;
    logic [W-1:0]                r_act;
    logic [W-1:0]                r_lr;
    logic [W-1:0]                r_err;
    logic [W-1:0]                r_scaled;
    logic [IW-1:0]               r_idx;

    logic signed [2*W-1:0]       w_diff;
    logic signed [2*W-1:0]       w_eprod;
    logic signed [2*W-1:0]       w_uprod;
    logic signed [2*W-1:0]       w_sum;
    logic [W-1:0]                w_err;
    logic [W-1:0]                w_scaled;
    logic [W-1:0]                w_xsel;
    logic [W-1:0]                w_wsel;
    logic [W-1:0]                w_delta;
    logic [W-1:0]                w_new;
    logic                        w_accept;

    assign w_accept  = start_valid && (r_state == S_IDLE);
    assign weights   = r_w;
    assign error_out = r_err;

    // Saturating arithmetic for the error/rate product and the weight update
    always_comb begin
        w_xsel = '0;
        w_wsel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (r_idx == IW'(i)) begin
                w_xsel = r_x[i];
                w_wsel = r_w[i];
            end
        end
        w_diff   = sx(r_tgt) - sx(r_act);
        w_err    = sat(w_diff);
        w_eprod  = sx(r_lr) * sx(w_err);
        w_scaled = sat(w_eprod >>> Q_N);
        w_uprod  = sx(r_scaled) * sx(w_xsel);
        w_delta  = sat(w_uprod >>> Q_N);
        w_sum    = sx(w_wsel) + sx(w_delta);
        w_new    = sat(w_sum);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode; a zero error skips the weight walk
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start_valid) w_next = S_CAPTURE;
            S_CAPTURE: w_next = (w_err == '0) ? S_DONE : S_UPDATE;
            S_UPDATE:  if (r_idx == IW'(N_INPUTS-1)) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE:    start_ready = 1'b1;
            S_CAPTURE: busy        = 1'b1;
            S_UPDATE:  busy        = 1'b1;
            S_DONE:    done        = 1'b1;
            default:   start_ready = 1'b0;
        endcase
    end

    // Sample latch, weight loads, error capture and per-cycle weight update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w      <= '0;
            r_x      <= '0;
            r_tgt    <= '0;
            r_act    <= '0;
            r_lr     <= '0;
            r_err    <= '0;
            r_scaled <= '0;
            r_idx    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tgt <= target;
                        r_act <= activation;
                        r_lr  <= learning_rate;
                        r_x   <= inputs;
                    end else if (load_valid) begin
                        for (int i = 0; i < N_INPUTS; i++)
                            if (load_index == IW'(i))
                                r_w[i] <= load_value;
                    end
                end
                S_CAPTURE: begin
                    r_err    <= w_err;
                    r_scaled <= w_scaled;
                    r_idx    <= '0;
                end
                S_UPDATE: begin
                    for (int i = 0; i < N_INPUTS; i++)
                        if (r_idx == IW'(i))
                            r_w[i] <= w_new;
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: directed cases plus random
// training steps compared against an arithmetic reference model.
module tb_perceptron_trainer;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_valid = 1'b0;
    logic [1:0]     load_index = '0;
    logic [W-1:0]   load_value = '0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   target = '0;
    logic [W-1:0]   activation = '0;
    logic [W-1:0]   learning_rate = '0;
    logic [N*W-1:0] inputs = '0;
    logic [N*W-1:0] weights;
    logic [W-1:0]   error_out;
    logic           busy;
    logic           done;

    int vectors = 0;
    int miscompares = 0;

    int m_w[N];
    int m_x[N];
    int m_err;

    perceptron_trainer dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_index   (load_index),
        .load_value   (load_value),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .target       (target),
        .activation   (activation),
        .learning_rate(learning_rate),
        .inputs       (inputs),
        .weights      (weights),
        .error_out    (error_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Clamp to the signed 32-bit range
    function automatic longint sat32(longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< 31) - 1;
        lo = -(longint'(1) <<< 31);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // One training step in plain arithmetic on the model weights
    function automatic void model_step(int tgt, int act, int lr);
        longint e;
        longint s;
        e = sat32(longint'(tgt) - longint'(act));
        m_err = int'(e);
        if (e == 0) return;
        s = sat32((longint'(lr) * e) >>> 16);
        for (int i = 0; i < N; i++)
            m_w[i] = int'(sat32(longint'(m_w[i]) +
                     sat32((s * longint'(m_x[i])) >>> 16)));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
    endtask

    task automatic load_w(input int idx, input int v);
        @(negedge clk);
        load_valid = 1'b1;
        load_index = 2'(idx);
        load_value = v;
        @(posedge clk);
        #1 load_valid = 1'b0;
        m_w[idx] = v;
    endtask

    // Accept one step and count cycles until done (cycle 0 = accept cycle)
    task automatic run_step(input int tgt, input int act, input int lr,
                            output int lat);
        @(negedge clk);
        target        = tgt;
        activation    = act;
        learning_rate = lr;
        inputs        = {m_x[3], m_x[2], m_x[1], m_x[0]};
        start_valid   = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (weights[i*W +: W] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_w%0d: got %h expected 00000000",
                         i, weights[i*W +: W]);
            end
        end
        vectors++;
        if (error_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_err: got %h expected 0", error_out);
        end
        vectors++;
        if ({start_ready, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 100",
                     {start_ready, busy, done});
        end
    endtask

    task automatic test_directed();
        int lat;
        int exp_w[N];
        exp_w = '{32'h00018000, 32'h00010000, 0, 32'hFFFF8000};
        do_reset();
        load_w(0, 32'h00010000);
        m_x = '{32'h00010000, 32'h00020000, 0, 32'hFFFF0000};
        run_step(32'h00010000, 0, 32'h00008000, lat);
        model_step(32'h00010000, 0, 32'h00008000);
        vectors++;
        if (lat != 6) begin
            miscompares++;
            $display("FAIL dir_latency: got %0d expected 6", lat);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (weights[i*W +: W] !== exp_w[i]) begin
                miscompares++;
                $display("FAIL dir_w%0d: got %h expected %h",
                         i, weights[i*W +: W], exp_w[i]);
            end
        end
        vectors++;
        if (error_out !== 32'h00010000) begin
            miscompares++;
            $display("FAIL dir_err: got %h expected 00010000", error_out);
        end
        @(negedge clk);
        vectors++;
        if ({start_ready, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL dir_pulse: got ready,done=%b expected 10",
                     {start_ready, done});
        end
    endtask

    task automatic test_zero_error();
        int lat;
        int exp_w[N];
        exp_w = m_w;
        run_step(32'h00010000, 32'h00010000, 32'h00008000, lat);
        model_step(32'h00010000, 32'h00010000, 32'h00008000);
        vectors++;
        if (lat != 2) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d expected 2", lat);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (weights[i*W +: W] !== exp_w[i]) begin
                miscompares++;
                $display("FAIL zero_w%0d: got %h expected %h",
                         i, weights[i*W +: W], exp_w[i]);
            end
        end
        vectors++;
        if (error_out !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_err: got %h expected 0", error_out);
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        load_w(0, 32'h7FFF0000);
        m_x = '{32'h00100000, 0, 0, 0};
        run_step(32'h00010000, 0, 32'h00010000, lat);
        vectors++;
        if (weights[0 +: W] !== 32'h7FFFFFFF) begin
            miscompares++;
            $display("FAIL sat_pos: got %h expected 7fffffff", weights[0 +: W]);
        end
        do_reset();
        load_w(0, 32'h80010000);
        run_step(0, 32'h00010000, 32'h00010000, lat);
        vectors++;
        if (weights[0 +: W] !== 32'h80000000) begin
            miscompares++;
            $display("FAIL sat_neg: got %h expected 80000000", weights[0 +: W]);
        end
        vectors++;
        if (error_out !== 32'hFFFF0000) begin
            miscompares++;
            $display("FAIL sat_neg_err: got %h expected ffff0000", error_out);
        end
        do_reset();
        load_w(1, 32'h00030000);
        m_x = '{32'h00010000, 32'h00010000, 0, 0};
        run_step(32'h7FFFFFFF, 32'h80000000, 0, lat);
        vectors++;
        if (error_out !== 32'h7FFFFFFF || lat != 6) begin
            miscompares++;
            $display("FAIL sat_err: got %h lat %0d expected 7fffffff lat 6",
                     error_out, lat);
        end
        vectors++;
        if (weights[W +: W] !== 32'h00030000) begin
            miscompares++;
            $display("FAIL lr0_w1: got %h expected 00030000", weights[W +: W]);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int bad_ready;
        int extra_done;
        do_reset();
        load_w(0, 32'h00020000);
        load_w(2, 32'hFFFE0000);
        m_x = '{32'h00010000, 32'h00008000, 32'h00030000, 32'hFFFF0000};
        @(negedge clk);
        target        = 32'h00010000;
        activation    = 0;
        learning_rate = 32'h00004000;
        inputs        = {m_x[3], m_x[2], m_x[1], m_x[0]};
        start_valid   = 1'b1;
        load_valid    = 1'b1;
        load_index    = 2'd0;
        load_value    = 32'h12345678;
        @(posedge clk);
        lat = -1;
        bad_ready = 0;
        extra_done = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (start_ready) bad_ready++;
            if (done) begin
                lat = c;
                start_valid = 1'b0;
                load_valid  = 1'b0;
                break;
            end
        end
        start_valid = 1'b0;
        load_valid  = 1'b0;
        model_step(32'h00010000, 0, 32'h00004000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        vectors++;
        if (lat != 6 || bad_ready != 0) begin
            miscompares++;
            $display("FAIL busy_hold: lat %0d ready_hits %0d expected 6 and 0",
                     lat, bad_ready);
        end
        vectors++;
        if (extra_done != 0) begin
            miscompares++;
            $display("FAIL busy_second: got %0d extra done expected 0",
                     extra_done);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (weights[i*W +: W] !== m_w[i]) begin
                miscompares++;
                $display("FAIL busy_w%0d: got %h expected %h",
                         i, weights[i*W +: W], m_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        int extra_done;
        do_reset();
        load_w(0, 32'h00010000);
        m_x = '{32'h00010000, 32'h00020000, 0, 32'hFFFF0000};
        @(negedge clk);
        target        = 32'h00010000;
        activation    = 0;
        learning_rate = 32'h00008000;
        inputs        = {m_x[3], m_x[2], m_x[1], m_x[0]};
        start_valid   = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (weights[0 +: W] !== 32'h00018000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got w0 %h busy %b expected 00018000 1",
                     weights[0 +: W], busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (weights[i*W +: W] !== 32'h0) begin
                miscompares++;
                $display("FAIL mid_w%0d: got %h expected 0",
                         i, weights[i*W +: W]);
            end
        end
        vectors++;
        if ({start_ready, busy, done} !== 3'b100 || error_out !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_flags: got %b err %h expected 100 err 0",
                     {start_ready, busy, done}, error_out);
        end
        extra_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        vectors++;
        if (extra_done != 0) begin
            miscompares++;
            $display("FAIL mid_done: got %0d done pulses expected 0",
                     extra_done);
        end
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        int tgt;
        int act;
        int lr;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                if ($urandom_range(0, 7) == 0)
                    load_w(int'($urandom_range(0, 3)), int'($urandom));
                else
                    load_w(int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 32'h100000)) - 32'h80000);
            end
            for (int i = 0; i < N; i++)
                m_x[i] = int'($urandom_range(0, 32'h80000)) - 32'h40000;
            tgt = $urandom_range(0, 1) ? 32'h00010000 : 0;
            act = $urandom_range(0, 1) ? 32'h00010000 : 0;
            if ($urandom_range(0, 3) == 0) act = int'($urandom);
            lr = int'($urandom_range(0, 32'h20000));
            model_step(tgt, act, lr);
            exp_lat = (m_err == 0) ? 2 : 6;
            run_step(tgt, act, lr, lat);
            vectors++;
            if (lat != exp_lat || error_out !== m_err) begin
                miscompares++;
                $display("FAIL rnd%0d_step: lat %0d err %h expected %0d %h",
                         it, lat, error_out, exp_lat, m_err);
            end
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (weights[i*W +: W] !== m_w[i]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_w%0d: got %h expected %h",
                             it, i, weights[i*W +: W], m_w[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_error();
        test_saturation();
        test_busy_ignore();
        test_reset_mid_update();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter SIGN, default 1, sign bit count of fixed-point words.
REQ-002 SHALL have parameter Q_M, default 15, integer bits.
REQ-003 SHALL have parameter Q_N, default 16, fractional bits; W = SIGN+Q_M+Q_N (32 by default), two's complement Q15.16.
REQ-004 SHALL have parameter N_INPUTS, default 4, number of weights (2..16).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 load_valid  input  1  request to write one weight (IDLE only).
REQ-008 load_index  input  $clog2(N_INPUTS)  weight index for load.
REQ-009 load_value  input  W  weight value for load.
REQ-010 start_valid  input  1  training-step request.
REQ-011 start_ready  output  1  high only in IDLE.
REQ-012 target  input  W  desired output (0.0 or 1.0 in Q format).
REQ-013 activation  input  W  perceptron output from the step activation stage.
REQ-014 learning_rate  input  W  learning rate, Q format, non-negative.
REQ-015 inputs  input  N_INPUTS*W  packed sample, element i at bits [i*W +: W].
REQ-016 weights  output  N_INPUTS*W  packed current weights, same packing.
REQ-017 error_out  output  W  latched error of last accepted step.
REQ-018 busy  output  1  high in CAPTURE and UPDATE.
REQ-019 done  output  1  one-cycle pulse when a step completes.

Function
REQ-020 FSM states SHALL be IDLE, CAPTURE, UPDATE, DONE.
REQ-021 IDLE->CAPTURE SHALL occur on start_valid&&start_ready; target, activation, learning_rate, inputs latched that edge.
REQ-022 CAPTURE SHALL compute error = sat(target - activation) and scaled = sat((learning_rate*error) >>> Q_N) into registers; error_out updated same edge.
REQ-023 CAPTURE->DONE SHALL occur when error==0 (no weight modified); otherwise CAPTURE->UPDATE with index=0.
REQ-024 UPDATE SHALL modify exactly one weight per cycle: w[i] <= sat(w[i] + sat((scaled*x[i]) >>> Q_N)); index increments; after i==N_INPUTS-1 go to DONE.
REQ-025 Products SHALL be full 2W-bit signed; shift arithmetic (truncate toward -inf); sat clamps to 0x7FFFFFFF/0x80000000 (W-bit max/min).
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 Latency accept-to-done SHALL be N_INPUTS+2 cycles when error!=0, 2 cycles when error==0.
REQ-028 load_valid SHALL write load_value to weight load_index only in IDLE; ignored in other states; ignored when start is accepted the same cycle (start wins).
REQ-029 start_valid outside IDLE SHALL be ignored (no queuing).
REQ-030 weights output SHALL reflect registers directly (updated weight visible cycle after its UPDATE edge).

Reset
REQ-031 rst SHALL force IDLE, all weights 0, error_out 0, index 0, done 0, busy 0, start_ready 1 on next edge, including mid-UPDATE (partial updates discarded only for weights not yet written; written weights also cleared to 0).

Verification
REQ-032 Reset then load w=[0x00010000,0,0,0], start target=0x00010000, activation=0, lr=0x00008000 (0.5), inputs=[0x00010000,0x00020000,0,0xFFFF0000] -> done at cycle 6 after accept; weights=[0x00018000,0x00010000,0,0xFFFF8000]; error_out=0x00010000.
REQ-033 target=activation=0x00010000 -> done 2 cycles after accept, weights unchanged, error_out=0.
REQ-034 w[0]=0x7FFF0000, lr=0x00010000, error +1.0, x[0]=0x00100000 -> w[0]=0x7FFFFFFF (saturated); symmetric negative case -> 0x80000000.
REQ-035 start_valid held high during UPDATE and load_valid during busy -> start_ready=0, no second step, weights untouched by load.
REQ-036 Assert rst at 2nd UPDATE cycle -> next cycle all weights 0, IDLE, start_ready=1, no done pulse.
